instr_packer: RTL and testbench
===============================

Name: instr_packer

Overview:
- Sequential counterpart of the D-stage field splitter: accepts decoded instruction fields (op, rs, rt, rd, fun, imm16, i26) plus a format selector, and packs them into 32-bit MIPS words.
- Buffers packed words in a small FIFO and emits each word with its target instruction-memory byte address.
- Used by the self-test loader and by directed instruction generators to stream programs into IM.

Parameters:
- DEPTH, 4, output FIFO depth in words; power of two, at least 2.
- BASE_ADDR, 32'h0000_3000, byte address assigned to the first emitted word after reset.

Ports:
- IPK_clk_i  in  1  clock; all logic is rising-edge.
- IPK_rst_n_i  in  1  synchronous active-low reset.
- IPK_fmt_i  in  2  packing format: 00 R, 01 I, 10 J, 11 illegal.
- IPK_op_i  in  6  opcode, placed in [31:26].
- IPK_fun_i  in  6  function field, placed in [5:0] (R only).
- IPK_rs_i  in  5  placed in [25:21] (R, I).
- IPK_rt_i  in  5  placed in [20:16] (R, I).
- IPK_rd_i  in  5  placed in [15:11] (R only).
- IPK_imm_i  in  16  placed in [15:0] (I only).
- IPK_i26_i  in  26  placed in [25:0] (J only).
- IPK_valid_i  in  1  input fields valid.
- IPK_ready_o  out  1  packer can accept.
- IPK_instr_o  out  32  packed instruction at FIFO head.
- IPK_addr_o  out  32  IM byte address of head word.
- IPK_valid_o  out  1  head word valid.
- IPK_ready_i  in  1  consumer accepts head word.
- IPK_err_o  out  1  sticky: an illegal format was presented.
- IPK_count_o  out  16  number of words emitted since reset.

Behaviour:
- Reset (IPK_rst_n_i low at a clock edge): FIFO empties; IPK_valid_o=0; IPK_ready_o=1 after the edge; IPK_err_o=0; IPK_count_o=0; address counter=BASE_ADDR; IPK_instr_o=0; IPK_addr_o=BASE_ADDR. Reset overrides any transfer in the same cycle; in-flight words are discarded.
- Input transfer: occurs on an edge where IPK_valid_i=1 and IPK_ready_o=1.
- IPK_ready_o = !full, registered-state derived only. It does not depend on IPK_ready_i, so a full FIFO does not accept input even in a cycle where a pop occurs.
- Packing per format; fields not used by the format are ignored and their bits are zero:
  - R: {op, rs, rt, rd, 5'b0, fun}.
  - I: {op, rs, rt, imm}.
  - J: {op, i26}.
- fmt=11 with a transfer: the word is dropped (no push) and IPK_err_o sets to 1, holding until reset. IPK_ready_o is unaffected.
- Latency: a word accepted at edge N into an empty FIFO shows IPK_valid_o=1 and its IPK_instr_o after edge N. There is no combinational bypass.
- Output transfer: occurs on an edge where IPK_valid_o=1 and IPK_ready_i=1.
  - Head pops.
  - Address counter advances by 4 and wraps modulo 2^32.
  - IPK_count_o increments and wraps 16'hFFFF to 0.
- IPK_addr_o always equals the address counter, i.e. the address of the current head.
- IPK_instr_o and IPK_addr_o must remain stable while IPK_valid_o=1 and IPK_ready_i=0.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged and order is preserved.
- Simultaneous push and pop when empty: only the push happens, since valid_o=0 means no pop.
- Implementation: FIFO uses read/write pointers with log2(DEPTH) bits plus one wrap bit. Full = pointers equal except the wrap bit; empty = pointers equal.
- Flags and counters are all registered.

Optional Feature:
- Macro: IPK_SHAMT_EN.
- Defined: adds input port IPK_shamt_i (5 bits), placed in [10:6] for the R format only.
- Undefined: the port is absent and [10:6] is always 0.
- The I and J formats ignore shamt in both builds.

Test Plan:
- Reset, then push R (op=0, rs=8, rt=9, rd=10, fun=6'h21) with IPK_ready_i=1 -> next cycle IPK_instr_o=32'h0109_5021, IPK_addr_o=32'h3000, valid_o=1; after the pop, count=1 and the address counter reads 32'h3004.
- Push I (op=6'h0D, rs=0, rt=1, imm=16'h1234), then J (op=6'h02, i26=26'h0000C00) with IPK_ready_i=0 -> head holds 32'h3401_1234 stably; release -> next word 32'h0800_0C00 at addr 32'h3004.
- Hold IPK_ready_i=0 and push 5 words with DEPTH=4 -> ready_o drops after the 4th acceptance; the 5th is held by the source; one pop frees exactly one slot and the 5th is accepted on the following edge.
- Present fmt=11 amid valid traffic -> err_o=1 after the edge, no word enqueued, count unaffected; err_o stays 1 until reset.
- Pulse reset with 3 words queued -> valid_o=0, count=0, addr_o=32'h3000 after the edge; subsequent pushes restart from BASE_ADDR.
- With IPK_SHAMT_EN defined, R (op=0, rt=2, rd=3, shamt=4, fun=0) -> 32'h0002_1900; without the macro, the same fields give 32'h0002_1800.

Source files
------------

// File: rtl/instr_packer.sv
// Packs decoded MIPS fields (R/I/J) into 32-bit words and streams them, with IM byte addresses, through a small FIFO.
// Optional build macro IPK_SHAMT_EN adds the IPK_shamt_i input (R-format bits [10:6]).
module instr_packer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        IPK_clk_i,
    input  logic        IPK_rst_n_i,
    input  logic [1:0]  IPK_fmt_i,
    input  logic [5:0]  IPK_op_i,
    input  logic [5:0]  IPK_fun_i,
    input  logic [4:0]  IPK_rs_i,
    input  logic [4:0]  IPK_rt_i,
    input  logic [4:0]  IPK_rd_i,
    input  logic [15:0] IPK_imm_i,
    input  logic [25:0] IPK_i26_i,
`ifdef IPK_SHAMT_EN
    input  logic [4:0]  IPK_shamt_i,
`endif
    input  logic        IPK_valid_i,
    output logic        IPK_ready_o,
    output logic [31:0] IPK_instr_o,
    output logic [31:0] IPK_addr_o,
    output logic        IPK_valid_o,
    input  logic        IPK_ready_i,
    output logic        IPK_err_o,
    output logic [15:0] IPK_count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_BAD = 2'b11
    } fmt_e;

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;

    logic [4:0]  shamt_w;
    logic [31:0] word_w;
    logic        full_w, empty_w, in_fire_w, push_w, pop_w;

`ifdef IPK_SHAMT_EN
    assign shamt_w = IPK_shamt_i;
`else
    assign shamt_w = 5'd0;
`endif

    // Full: same slot index, opposite wrap bit; empty: identical pointers.
    assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);

    always_comb begin
        word_w = 32'd0;
        case (fmt_e'(IPK_fmt_i))
            FMT_R:   word_w = {IPK_op_i, IPK_rs_i, IPK_rt_i, IPK_rd_i, shamt_w, IPK_fun_i};
            FMT_I:   word_w = {IPK_op_i, IPK_rs_i, IPK_rt_i, IPK_imm_i};
            FMT_J:   word_w = {IPK_op_i, IPK_i26_i};
            default: word_w = 32'd0;
        endcase

        in_fire_w = IPK_valid_i && !full_w;
        push_w    = in_fire_w && (IPK_fmt_i != FMT_BAD);
        pop_w     = !empty_w && IPK_ready_i;

        wr_ptr_d = push_w ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_w  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        addr_d   = pop_w  ? addr_q + 32'd4     : addr_q;
        count_d  = pop_w  ? count_q + 16'd1    : count_q;
        err_d    = err_q || (in_fire_w && (IPK_fmt_i == FMT_BAD));
    end

    always_ff @(posedge IPK_clk_i) begin
        if (!IPK_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= BASE_ADDR;
            count_q  <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is live.
    always_ff @(posedge IPK_clk_i) begin
        if (push_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= word_w;
        end
    end

    assign IPK_ready_o = !full_w;
    assign IPK_valid_o = !empty_w;
    assign IPK_instr_o = empty_w ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign IPK_addr_o  = addr_q;
    assign IPK_err_o   = err_q;
    assign IPK_count_o = count_q;

endmodule

// File: tb/tb_instr_packer.sv
// Directed self-checking bench for instr_packer; follows the IPK_SHAMT_EN build of the DUT.
module tb_instr_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  fmt;
    logic [5:0]  op, fun;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] i26;
`ifdef IPK_SHAMT_EN
    logic [4:0]  shamt;
`endif
    logic        valid_i, ready_o, valid_o, ready_i, err_o;
    logic [31:0] instr_o, addr_o;
    logic [15:0] count_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    instr_packer #(.DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
        .IPK_clk_i   (clk),
        .IPK_rst_n_i (rst_n),
        .IPK_fmt_i   (fmt),
        .IPK_op_i    (op),
        .IPK_fun_i   (fun),
        .IPK_rs_i    (rs),
        .IPK_rt_i    (rt),
        .IPK_rd_i    (rd),
        .IPK_imm_i   (imm),
        .IPK_i26_i   (i26),
`ifdef IPK_SHAMT_EN
        .IPK_shamt_i (shamt),
`endif
        .IPK_valid_i (valid_i),
        .IPK_ready_o (ready_o),
        .IPK_instr_o (instr_o),
        .IPK_addr_o  (addr_o),
        .IPK_valid_o (valid_o),
        .IPK_ready_i (ready_i),
        .IPK_err_o   (err_o),
        .IPK_count_o (count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_i(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                           input logic [15:0] im);
        fmt = 2'b01; op = o; rs = s; rt = t; imm = im; valid_i = 1'b1;
        $display("[TB] present I op=%h rs=%0d rt=%0d imm=%h", o, s, t, im);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_shamt_word;

    initial begin
        rst_n = 1'b0; fmt = 2'b00; op = '0; fun = '0; rs = '0; rt = '0; rd = '0;
        imm = '0; i26 = '0; valid_i = 1'b0; ready_i = 1'b0;
`ifdef IPK_SHAMT_EN
        shamt = '0;
        exp_shamt_word = 32'h0002_1900;
`else
        exp_shamt_word = 32'h0002_1800;
`endif
        step(); step();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_err",   err_o,   0);
        check("rst_count", count_o, 0);
        check("rst_addr",  addr_o,  32'h3000);
        check("rst_instr", instr_o, 0);
        rst_n = 1'b1;

        // R word, consumer ready
        fmt = 2'b00; op = 6'h00; rs = 5'd8; rt = 5'd9; rd = 5'd10; fun = 6'h21;
        valid_i = 1'b1; ready_i = 1'b1;
        $display("[TB] present R rs=8 rt=9 rd=10 fun=21");
        step();
        valid_i = 1'b0;
        check("r_valid", valid_o, 1);
        check("r_instr", instr_o, 32'h0109_5021);
        check("r_addr",  addr_o,  32'h3000);
        step();
        check("r_count", count_o, 1);
        check("r_addr_after", addr_o, 32'h3004);
        check("r_empty", valid_o, 0);

        // I then J with consumer stalled
        pulse_reset();
        ready_i = 1'b0;
        drive_i(6'h0D, 5'd0, 5'd1, 16'h1234);
        step();
        fmt = 2'b10; op = 6'h02; i26 = 26'h0000C00;
        $display("[TB] present J op=02 i26=0000c00");
        step();
        valid_i = 1'b0;
        check("ij_head",  instr_o, 32'h3401_1234);
        check("ij_addr",  addr_o,  32'h3000);
        step();
        check("ij_stable_instr", instr_o, 32'h3401_1234);
        check("ij_stable_addr",  addr_o,  32'h3000);
        ready_i = 1'b1;
        step();
        check("j_head",  instr_o, 32'h0800_0C00);
        check("j_addr",  addr_o,  32'h3004);
        check("j_count", count_o, 1);
        step();
        check("ij_drained", valid_o, 0);
        check("ij_count",   count_o, 2);
        ready_i = 1'b0;

        // Fill to DEPTH, fifth word must wait for a slot
        for (int k = 1; k <= 4; k++) begin
            check("fill_ready", ready_o, 1);
            drive_i(6'h08, 5'd0, 5'd0, 16'(k));
            step();
        end
        check("full_ready", ready_o, 0);
        drive_i(6'h08, 5'd0, 5'd0, 16'd5);
        step();
        check("held_ready", ready_o, 0);
        check("held_head",  instr_o, 32'h2000_0001);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("slot_ready", ready_o, 1);
        check("slot_head",  instr_o, 32'h2000_0002);
        step();
        valid_i = 1'b0;
        check("fifth_in_ready", ready_o, 0);
        ready_i = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check("order_instr", instr_o, 32'h2000_0000 | 32'(k));
            check("order_addr",  addr_o,  32'h3008 + 32'(4 * (k - 1)));
            step();
        end
        check("fill_drained", valid_o, 0);
        check("fill_count",   count_o, 7);
        ready_i = 1'b0;

        // Illegal format between two legal words
        drive_i(6'h08, 5'd0, 5'd0, 16'hAAAA);
        step();
        check("pre_err", err_o, 0);
        fmt = 2'b11;
        $display("[TB] present illegal fmt=11");
        step();
        check("err_set", err_o, 1);
        drive_i(6'h08, 5'd0, 5'd0, 16'hBBBB);
        step();
        valid_i = 1'b0;
        ready_i = 1'b1;
        check("bad_head_a", instr_o, 32'h2000_AAAA);
        step();
        check("bad_head_b", instr_o, 32'h2000_BBBB);
        step();
        check("bad_drained", valid_o, 0);
        check("bad_count",   count_o, 9);
        check("err_sticky",  err_o, 1);
        ready_i = 1'b0;

        // Reset with words queued
        for (int k = 0; k < 3; k++) begin
            drive_i(6'h08, 5'd0, 5'd0, 16'(k));
            step();
        end
        valid_i = 1'b0;
        check("q3_valid", valid_o, 1);
        pulse_reset();
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_count", count_o, 0);
        check("mid_rst_addr",  addr_o,  32'h3000);
        check("mid_rst_err",   err_o,   0);
        check("mid_rst_ready", ready_o, 1);

        // R word exercising the shift-amount field
        fmt = 2'b00; op = 6'h00; rs = 5'd0; rt = 5'd2; rd = 5'd3; fun = 6'h00;
`ifdef IPK_SHAMT_EN
        shamt = 5'd4;
`endif
        valid_i = 1'b1;
        $display("[TB] present R rt=2 rd=3 shamt=4 fun=0");
        step();
        valid_i = 1'b0;
        check("shamt_instr", instr_o, exp_shamt_word);
        check("shamt_addr",  addr_o,  32'h3000);
        ready_i = 1'b1;
        step();
        check("shamt_count", count_o, 1);
        check("shamt_addr_after", addr_o, 32'h3004);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
